// File: rtl/iter_muldiv_unit.sv
// iter_muldiv_unit
//   Multi-cycle multiply / signed divide / signed remainder for the EX stage.
//   One bit per cycle; every op (including the special cases) takes the same
//   fixed latency: start accepted at edge N, done_o high in the cycle that
//   follows edge N+XLEN.
//
// Ports
//   clk_i     rising-edge clock
//   rst_i     asynchronous reset, active low
//   start_i   request strobe, sampled only in IDLE
//   op_i      00 MUL (low half), 01 DIV, 10 REM, 11 reserved (result 0)
//   data1_i   multiplicand / dividend
//   data2_i   multiplier / divisor
//   flush_i   abort the operation in flight (also cancels a pending done_o)
//   busy_o    operation in progress (RUN)
//   done_o    one-cycle result-valid pulse
//   result_o  result, held until the next completed operation
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | one shift-add / restoring-divide step per cycle, XLEN cycles
// DONE  | result presented with done_o, committed unless flushed

module iter_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_DIV = 2'd1;
  localparam logic [1:0] OP_REM = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;       // raw multiplicand
  logic [XLEN-1:0]   b_q, b_d;       // divisor magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;   // MUL: {partial, multiplier}; DIV: {rem, quot}
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   mag1, mag2;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] mul_step, div_step;
  logic [XLEN-1:0]   quot, rem, final_res;

  // The most-negative value maps onto itself, which is also its correct
  // unsigned magnitude.
  assign mag1 = data1_i[XLEN-1] ? -data1_i : data1_i;
  assign mag2 = data2_i[XLEN-1] ? -data2_i : data2_i;

  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring division: shift the next dividend bit into the remainder and
  // keep the subtraction only when it does not go negative.
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, b_q};
  assign div_step  = div_trial[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  assign quot = acc_q[XLEN-1:0];
  assign rem  = acc_q[2*XLEN-1:XLEN];

  // Overflow (most-negative / -1) falls out of the magnitude arithmetic;
  // only the zero-divisor quotient needs an override. A zero divisor leaves
  // the dividend magnitude in the remainder, so REM already yields data1.
  always_comb begin
    final_res = '0;
    case (op_q)
      OP_MUL:  final_res = acc_q[XLEN-1:0];
      OP_DIV:  final_res = (b_q == '0) ? '1 : (negq_q ? -quot : quot);
      OP_REM:  final_res = negr_q ? -rem : rem;
      default: final_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          state_d = S_RUN;
          op_d    = op_i;
          a_d     = data1_i;
          b_d     = mag2;
          cnt_d   = '0;
          negq_d  = data1_i[XLEN-1] ^ data2_i[XLEN-1];
          negr_d  = data1_i[XLEN-1];
          acc_d   = (op_i == OP_MUL) ? {{XLEN{1'b0}}, data2_i} : {{XLEN{1'b0}}, mag1};
        end
      end
      S_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = (op_q == OP_MUL) ? mul_step : div_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          result_d = final_res;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q == S_RUN);
  assign done_o   = (state_q == S_DONE) && !flush_i;
  // The new value is visible in the DONE cycle itself; a flush there keeps
  // the previously committed result on the output.
  assign result_o = done_o ? final_res : result_q;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
module tb_iter_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_res;

  iter_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .data1_i (data1_i),
    .data2_i (data2_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: RISC-V M-extension semantics in plain integer arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      2'd0: return a * b;
      2'd1: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      2'd2: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Presents a request in an IDLE cycle; returns just after the accepting edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk_i); #1;
    check("idle_done_low", {31'd0, done_o}, 32'd0);
    check("idle_result_held", result_o, exp_res);
    start_i = 1'b1;
    op_i    = op;
    data1_i = a;
    data2_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    data1_i = $urandom;
    data2_i = $urandom;
    op_i    = 2'($urandom_range(0, 3));
  endtask

  // k counts sample points; k = 1 is just after the accepting edge.
  task automatic wait_done(input bit poke_run, output int k, output int nbusy);
    k = 1;
    nbusy = 0;
    while (!done_o && k < 40) begin
      if (busy_o) nbusy++;
      start_i = (poke_run && k == 10);
      @(posedge clk_i); #1;
      k++;
    end
    start_i = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit poke_run);
    int k;
    int nbusy;
    logic [31:0] expv;
    expv = model(op, a, b);
    start_op(op, a, b);
    wait_done(poke_run, k, nbusy);
    check({tag, "_latency"}, 32'(k), 32'd33);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd32);
    check({tag, "_busy_at_done"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_result"}, result_o, expv);
    exp_res = expv;
  endtask

  task automatic count_dones(input int ncyc, output int nd);
    nd = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk_i); #1;
      if (done_o) nd++;
    end
  endtask

  initial begin
    int k;
    int nbusy;
    int nd;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_i   = 1'b0;
    start_i = 1'b0;
    op_i    = 2'd0;
    data1_i = 32'd0;
    data2_i = 32'd0;
    flush_i = 1'b0;
    exp_res = 32'd0;
    #22;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    run_op("mul_7x-3", 2'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op("div_-7/2", 2'd1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("rem_-7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("rem_7/-2", 2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op("div_5/0", 2'd1, 32'd5, 32'd0, 1'b0);
    run_op("rem_5/0", 2'd2, 32'd5, 32'd0, 1'b0);
    run_op("div_ovf", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("mul_wrap", 2'd0, 32'h0001_0000, 32'h0001_0000, 1'b0);
    run_op("op_rsvd", 2'd3, 32'd9, 32'd3, 1'b0);
    // Start held in RUN is ignored: latency unchanged and no second done.
    run_op("run_start_ign", 2'd0, 32'd11, 32'd13, 1'b1);
    count_dones(40, nd);
    check("run_start_no_extra_done", 32'(nd), 32'd0);

    // Start presented during DONE is ignored.
    start_op(2'd0, 32'd6, 32'd6);
    wait_done(1'b0, k, nbusy);
    check("done_start_latency", 32'(k), 32'd33);
    exp_res = 32'd36;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("done_start_ign_busy", {31'd0, busy_o}, 32'd0);
    count_dones(40, nd);
    check("done_start_no_done", 32'(nd), 32'd0);

    // Flush in RUN keeps the previous result and produces no done.
    run_op("mul_7x-3_again", 2'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    start_op(2'd1, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk_i); #1;
    end
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check("flush_run_busy", {31'd0, busy_o}, 32'd0);
    check("flush_run_done", {31'd0, done_o}, 32'd0);
    check("flush_run_result", result_o, 32'hFFFF_FFEB);
    count_dones(40, nd);
    check("flush_run_no_done", 32'(nd), 32'd0);
    run_op("div_100/7", 2'd1, 32'd100, 32'd7, 1'b0);

    // Flush in DONE cancels the pulse and the result write.
    start_op(2'd0, 32'd5, 32'd5);
    wait_done(1'b0, k, nbusy);
    check("flush_done_latency", 32'(k), 32'd33);
    flush_i = 1'b1;
    #1;
    check("flush_done_pulse", {31'd0, done_o}, 32'd0);
    check("flush_done_result", result_o, 32'd14);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check("flush_done_result_kept", result_o, 32'd14);

    // Flush together with start in IDLE drops the start.
    start_i = 1'b1;
    flush_i = 1'b1;
    op_i    = 2'd0;
    data1_i = 32'd2;
    data2_i = 32'd2;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    check("flush_start_busy", {31'd0, busy_o}, 32'd0);
    count_dones(40, nd);
    check("flush_start_no_done", 32'(nd), 32'd0);

    // Asynchronous reset mid-operation.
    start_op(2'd2, 32'd77, 32'd5);
    repeat (4) begin
      @(posedge clk_i); #1;
    end
    #2;
    rst_i = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    check("rst_mid_done", {31'd0, done_o}, 32'd0);
    check("rst_mid_result", result_o, 32'd0);
    exp_res = 32'd0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    run_op("mul_3x4", 2'd0, 32'd3, 32'd4, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($signed(ra) >>> 20); rb = 32'($signed(rb) >>> 26); end
        default: ;
      endcase
      run_op("rand", rop, ra, rb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed no end, expected end");
    $fatal(1, "timeout");
  end

endmodule
